// File: rtl/timer_tick_driver.sv
// -----------------------------------------------------------------------------
// timer_tick_driver
//
// Controller for the countdown digit timer. It issues the one-cycle load pulse
// (reconfig), derives the one-second decrement strobe (OneSecTimer) from clk,
// and stops the countdown when the digit timer reports TimeOut. It also reports
// run/expired status to the game access controller.
//
// Parameters:
//   TICKS_PER_SEC  clk cycles per one-second strobe (2 .. 2^32-1)
//   CNT_W          prescaler width, 2^CNT_W must exceed TICKS_PER_SEC
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   one-cycle request to begin a countdown
//   abort        in   one-cycle request to cancel a running countdown
//   TimeOut      in   level from digit timer, high when count reached zero
//   pause        in   (TIMER_TICK_PAUSE_EN only) freeze prescaler while in RUN
//   reconfig     out  one-cycle load pulse to the digit timer
//   OneSecTimer  out  one-cycle decrement strobe to the digit timer
//   running      out  high while a countdown is active
//   expired      out  high after a countdown ended by TimeOut
//
// Optional feature macro: TIMER_TICK_PAUSE_EN adds the pause input.
//
// All outputs are registered: each is computed from the next state and next
// prescaler value, so there is no combinational path from any input.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module timer_tick_driver #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic TimeOut,
`ifdef TIMER_TICK_PAUSE_EN
  input  logic pause,
`endif
  output logic reconfig,
  output logic OneSecTimer,
  output logic running,
  output logic expired
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Prescaler value held during the strobe cycle.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             advance;
  logic             hold;
  logic             strobe_nxt;

`ifdef TIMER_TICK_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    advance   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        // abort has no meaning here, so start always wins
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
      S_RUN: begin
        // priority: abort, then TimeOut, then normal counting
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (TimeOut) begin
          state_nxt = S_DONE;
        end else if (!hold) begin
          advance = 1'b1;
          cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobe only on arrival at LAST; a frozen prescaler sitting at LAST does
  // not re-issue it, and leaving RUN suppresses it.
  assign strobe_nxt = advance && (cnt_nxt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      reconfig    <= 1'b0;
      OneSecTimer <= 1'b0;
      running     <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      reconfig    <= (state_nxt == S_LOAD);
      OneSecTimer <= strobe_nxt;
      running     <= (state_nxt == S_RUN);
      expired     <= (state_nxt == S_DONE);
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(reconfig && OneSecTimer));
  a_strobe_in_run: assert property (@(posedge clk) disable iff (rst)
    OneSecTimer |-> running);
  a_exp_not_run: assert property (@(posedge clk) disable iff (rst)
    !(expired && running));

endmodule
